// File: rtl/sound_ctrl_pkg.sv
// Shared sound definitions: sequencer state/kind enums, default tone lengths
// (also used by the collision oscillator) and a counter-width helper.
package sound_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } snd_state_e;

    typedef enum logic {
        GOOD = 1'b0,
        BAD  = 1'b1
    } snd_kind_e;

    // Must match the oscillator's good/bad tone timers.
    localparam int unsigned GOOD_LEN_DEF = 4000000;
    localparam int unsigned BAD_LEN_DEF  = 10000000;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sound_ctrl_snd_square.sv
// Square-wave speaker driver: toggles on each enabled oscillator strobe,
// synchronous clear has priority over the toggle.
module snd_square (
    input  logic clk,
    input  logic nRst,
    input  logic at_max,
    input  logic en,
    input  logic clr,
    output logic spk
);

    // Speaker flip-flop: clear wins, otherwise toggle on enabled strobe.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            spk <= 1'b0;
        end else if (clr) begin
            spk <= 1'b0;
        end else if (en && at_max) begin
            spk <= ~spk;
        end
    end

endmodule

// File: rtl/sound_ctrl.sv
// Sound-event sequencer: latches eat/hit events, launches one tone at a time
// towards the collision oscillator, times the tone (with a strobe watchdog),
// inserts a silent gap, and turns the oscillator strobe into a speaker pin.
//
// state | meaning
// IDLE  | waiting; launches the highest-priority pending event (hit first)
// PLAY  | tone running for GOOD_LEN/BAD_LEN cycles, watchdog on at_max
// GAP   | GAP_LEN silent cycles so the oscillator fully releases
module sound_ctrl
    import sound_ctrl_pkg::*;
#(
    parameter int unsigned GOOD_LEN = GOOD_LEN_DEF,
    parameter int unsigned BAD_LEN  = BAD_LEN_DEF,
    parameter int unsigned GAP_LEN  = 1024,
    parameter int unsigned WDOG     = 512,
    parameter int unsigned CW       = 24
) (
    input  logic clk,
    input  logic nRst,
    input  logic eat_evt,
    input  logic hit_evt,
    input  logic mute,
    input  logic at_max,
    output logic goodColl,
    output logic badColl,
    output logic spk,
    output logic busy,
    output logic osc_fault
);

    localparam int unsigned WW = cnt_width(WDOG);
    localparam int unsigned GW = cnt_width(GAP_LEN);

    localparam logic [CW-1:0] GOOD_LAST = CW'(GOOD_LEN - 1);
    localparam logic [CW-1:0] BAD_LAST  = CW'(BAD_LEN - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(WDOG - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

    snd_state_e    state;
    snd_state_e    next_state;
    snd_kind_e     kind;
    snd_kind_e     launch_kind;
    logic          launch;
    logic          play_done;
    logic          wd_abort;
    logic          eat_pend;
    logic          hit_pend;
    logic [CW-1:0] dur;
    logic [CW-1:0] dur_last;
    logic [WW-1:0] wd;
    logic [GW-1:0] gcnt;
    logic          spk_en;
    logic          spk_clr;

    assign dur_last = (kind == BAD) ? BAD_LAST : GOOD_LAST;

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, launch decision and tone termination conditions.
    always_comb begin
        next_state  = state;
        launch      = 1'b0;
        launch_kind = GOOD;
        play_done   = 1'b0;
        wd_abort    = 1'b0;
        case (state)
            IDLE: begin
                if (hit_pend) begin
                    launch      = 1'b1;
                    launch_kind = BAD;
                    next_state  = PLAY;
                end else if (eat_pend) begin
                    launch      = 1'b1;
                    launch_kind = GOOD;
                    next_state  = PLAY;
                end
            end
            PLAY: begin
                play_done = (dur == dur_last);
                wd_abort  = !at_max && (wd == WD_LAST);
                if (play_done || wd_abort) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Combinational outputs: speaker enable/clear and busy.
    always_comb begin
        spk_en  = (state == PLAY) && !mute;
        spk_clr = mute || (next_state != PLAY);
        busy    = (state != IDLE) || eat_pend || hit_pend;
    end

    // Pending flags: a new event in the launch cycle keeps its flag set.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            eat_pend <= 1'b0;
            hit_pend <= 1'b0;
        end else begin
            eat_pend <= (eat_evt && !mute) || (eat_pend && !(launch && launch_kind == GOOD));
            hit_pend <= (hit_evt && !mute) || (hit_pend && !(launch && launch_kind == BAD));
        end
    end

    // Registered requests, tone kind and watchdog fault pulse.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            kind      <= GOOD;
            goodColl  <= 1'b0;
            badColl   <= 1'b0;
            osc_fault <= 1'b0;
        end else begin
            if (launch) begin
                kind <= launch_kind;
            end
            goodColl  <= launch && (launch_kind == GOOD);
            badColl   <= launch && (launch_kind == BAD);
            osc_fault <= wd_abort;
        end
    end

    // Duration, watchdog and gap counters; each restarts at 0 on state entry.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            dur  <= '0;
            wd   <= '0;
            gcnt <= '0;
        end else begin
            if (state == PLAY && next_state == PLAY) begin
                dur <= dur + 1'b1;
            end else begin
                dur <= '0;
            end
            if (state == PLAY && next_state == PLAY && !at_max) begin
                wd <= wd + 1'b1;
            end else begin
                wd <= '0;
            end
            if (state == GAP && next_state == GAP) begin
                gcnt <= gcnt + 1'b1;
            end else begin
                gcnt <= '0;
            end
        end
    end

    snd_square u_square (
        .clk    (clk),
        .nRst   (nRst),
        .at_max (at_max),
        .en     (spk_en),
        .clr    (spk_clr),
        .spk    (spk)
    );

endmodule

// File: tb/tb_sound_ctrl.sv
// Bench for sound_ctrl: directed scenarios plus a random event phase, all
// checked every cycle against a timestamp-based reference model.
module tb_sound_ctrl;

    localparam int GOOD_LEN = 40;
    localparam int BAD_LEN  = 100;
    localparam int GAP_LEN  = 4;
    localparam int WDOG     = 16;
    localparam int PERIOD   = 5;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic eat_evt = 1'b0;
    logic hit_evt = 1'b0;
    logic mute = 1'b0;
    logic at_max = 1'b0;
    logic goodColl, badColl, spk, busy, osc_fault;

    sound_ctrl #(
        .GOOD_LEN (GOOD_LEN),
        .BAD_LEN  (BAD_LEN),
        .GAP_LEN  (GAP_LEN),
        .WDOG     (WDOG),
        .CW       (24)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .eat_evt   (eat_evt),
        .hit_evt   (hit_evt),
        .mute      (mute),
        .at_max    (at_max),
        .goodColl  (goodColl),
        .badColl   (badColl),
        .spk       (spk),
        .busy      (busy),
        .osc_fault (osc_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // oscillator model
    bit osc_en = 1'b1;
    bit osc_on = 1'b0;
    int osc_t0 = 0;
    int osc_len = 0;

    // reference model (timestamps relative to cyc)
    int cyc = 0;
    bit m_eat = 1'b0, m_hit = 1'b0;
    bit in_play = 1'b0;
    int idle_from = 0;
    int t_start = 0;
    bit t_kind = 1'b0;
    int last_at = 0;
    int fault_at = -1;
    int tog = 0;
    bit exp_good = 1'b0, exp_bad = 1'b0;

    // observation counters
    int n_good = 0, n_bad = 0, n_fault = 0, n_tog = 0;
    int req_q[$];
    int req_cyc_q[$];
    int fault_cyc = -1;
    int busy_fall_cyc = -1;
    logic spk_prev = 1'b0;
    logic busy_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tone_len(input bit k);
        return k ? BAD_LEN : GOOD_LEN;
    endfunction

    task automatic model_reset();
        m_eat = 0; m_hit = 0; in_play = 0; idle_from = 0;
        fault_at = -1; tog = 0; osc_on = 0;
        spk_prev = 0; busy_prev = 0;
    endtask

    task automatic tick();
        bit idle_now, launch, lkind, abort, exp_spk;
        at_max = osc_en && osc_on && (cyc >= osc_t0) && (cyc < osc_t0 + osc_len)
                 && ((cyc - osc_t0) % PERIOD == PERIOD - 1);
        idle_now = !in_play && (cyc >= idle_from);
        launch = idle_now && (m_hit || m_eat);
        lkind = m_hit;
        if (in_play) begin
            abort = !at_max && (cyc - (last_at + 1) == WDOG - 1);
            if (at_max) last_at = cyc;
            if (mute) tog = 0;
            else if (at_max) tog++;
            if ((cyc == t_start + tone_len(t_kind) - 1) || abort) begin
                in_play = 0;
                idle_from = cyc + 1 + GAP_LEN;
                if (abort) fault_at = cyc + 1;
            end
        end
        if (launch) begin
            in_play = 1; t_start = cyc + 1; t_kind = lkind; last_at = cyc; tog = 0;
        end
        m_hit = (hit_evt && !mute) || (m_hit && !(launch && lkind));
        m_eat = (eat_evt && !mute) || (m_eat && !(launch && !lkind));
        exp_good = launch && !lkind;
        exp_bad  = launch && lkind;
        exp_spk  = in_play && !mute && (tog % 2 == 1);

        @(posedge clk);
        #1;
        cyc++;
        chk("goodColl", goodColl, exp_good);
        chk("badColl", badColl, exp_bad);
        chk("osc_fault", osc_fault, cyc == fault_at);
        chk("busy", busy, in_play || (cyc < idle_from) || m_hit || m_eat);
        chk("spk", spk, exp_spk);

        if (goodColl) begin
            n_good++; req_q.push_back(0); req_cyc_q.push_back(cyc);
            osc_on = 1; osc_t0 = cyc; osc_len = GOOD_LEN;
        end
        if (badColl) begin
            n_bad++; req_q.push_back(1); req_cyc_q.push_back(cyc);
            osc_on = 1; osc_t0 = cyc; osc_len = BAD_LEN;
        end
        if (osc_fault) begin n_fault++; fault_cyc = cyc; end
        if (spk !== spk_prev) n_tog++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        spk_prev = spk;
        busy_prev = busy;
        eat_evt = 0;
        hit_evt = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0, b0, t0, f0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_goodColl", goodColl, 0);
        chk("rst_badColl", badColl, 0);
        chk("rst_spk", spk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_osc_fault", osc_fault, 0);
        nRst = 1;
        model_reset();
        run(3);

        // 1: single eat tone
        req_q.delete(); req_cyc_q.delete();
        g0 = n_good; b0 = n_bad; t0 = n_tog;
        eat_evt = 1; tick();
        run(60);
        chk("t1_good_count", n_good - g0, 1);
        chk("t1_bad_count", n_bad - b0, 0);
        chk("t1_spk_toggles", n_tog - t0, 8);
        chk("t1_play_plus_gap", busy_fall_cyc - req_cyc_q[0], GOOD_LEN + GAP_LEN);
        chk("t1_busy_end", busy, 0);

        // 2: simultaneous eat and hit, hit first
        req_q.delete(); req_cyc_q.delete();
        eat_evt = 1; hit_evt = 1; tick();
        run(165);
        chk("t2_req_count", req_q.size(), 2);
        if (req_q.size() == 2) begin
            chk("t2_first_bad", req_q[0], 1);
            chk("t2_second_good", req_q[1], 0);
            chk("t2_spacing", req_cyc_q[1] - req_cyc_q[0], BAD_LEN + GAP_LEN + 1);
        end

        // 3: repeated eats during PLAY collapse into one
        req_q.delete(); req_cyc_q.delete();
        eat_evt = 1; tick();
        run(10);
        for (int k = 0; k < 3; k++) begin
            eat_evt = 1; tick();
            run($urandom_range(2, 6));
        end
        run(100);
        chk("t3_req_count", req_q.size(), 2);
        if (req_q.size() == 2) begin
            chk("t3_both_good", req_q[0] + req_q[1], 0);
            chk("t3_spacing", req_cyc_q[1] - req_cyc_q[0], GOOD_LEN + GAP_LEN + 1);
        end

        // 4: no strobes, watchdog abort
        req_q.delete(); req_cyc_q.delete();
        osc_en = 0;
        f0 = n_fault; t0 = n_tog;
        eat_evt = 1; tick();
        run(30);
        chk("t4_fault_count", n_fault - f0, 1);
        if (req_cyc_q.size() == 1)
            chk("t4_fault_delay", fault_cyc - req_cyc_q[0], WDOG);
        else
            chk("t4_req_count", req_cyc_q.size(), 1);
        chk("t4_spk_toggles", n_tog - t0, 0);
        chk("t4_busy_end", busy, 0);
        osc_en = 1;

        // 5: muted event dropped, muted tone keeps timing
        req_q.delete(); req_cyc_q.delete();
        g0 = n_good;
        mute = 1;
        eat_evt = 1; tick();
        run(10);
        chk("t5_muted_evt_dropped", n_good - g0, 0);
        chk("t5_idle_busy", busy, 0);
        mute = 0;
        eat_evt = 1; tick();
        mute = 1;
        t0 = n_tog;
        run(20);
        eat_evt = 1; tick();
        run(40);
        chk("t5_good_count", n_good - g0, 1);
        chk("t5_spk_silent", n_tog - t0, 0);
        if (req_cyc_q.size() == 1)
            chk("t5_play_plus_gap", busy_fall_cyc - req_cyc_q[0], GOOD_LEN + GAP_LEN);
        mute = 0;
        run(5);

        // 6: reset mid-PLAY
        g0 = n_good; b0 = n_bad;
        eat_evt = 1; tick();
        run(12);
        hit_evt = 1; tick();
        run(3);
        #2;
        nRst = 0;
        #1;
        chk("t6_rst_goodColl", goodColl, 0);
        chk("t6_rst_badColl", badColl, 0);
        chk("t6_rst_spk", spk, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_osc_fault", osc_fault, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nRst = 1;
        model_reset();
        g0 = n_good; b0 = n_bad;
        run(60);
        chk("t6_no_stale_good", n_good - g0, 0);
        chk("t6_no_stale_bad", n_bad - b0, 0);
        chk("t6_busy_after", busy, 0);

        // random phase
        for (int i = 0; i < 2000; i++) begin
            eat_evt = ($urandom_range(0, 39) == 0);
            hit_evt = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
            if ($urandom_range(0, 199) == 0) osc_en = ~osc_en;
            tick();
        end
        mute = 0;
        osc_en = 1;
        run(300);
        chk("rand_drained_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_ctrl.md
Name: sound_ctrl

Overview:
Sound-event sequencer that drives the collision-tone oscillator and consumes its output. It latches game sound events (apple eaten, wall/self hit) and issues one-cycle goodColl/badColl requests to the oscillator one tone at a time. It converts the oscillator's at_max strobe into a square-wave speaker pin. It sits between the game-logic FSM and the oscillator/speaker pad.

Parameters:
GOOD_LEN, 4000000, PLAY duration in clk cycles for an eat tone; must match the oscillator's good timer.
BAD_LEN, 10000000, PLAY duration in clk cycles for a hit tone; must match the oscillator's bad timer.
GAP_LEN, 1024, silent cycles after every tone, so the oscillator has fully released before the next request.
WDOG, 512, maximum cycles allowed in PLAY without an at_max strobe before the tone is aborted.
CW, 24, width of the duration counter; must hold BAD_LEN.

Ports:
clk  in  1  system clock
nRst  in  1  reset, asynchronous, active-low
eat_evt  in  1  single-cycle pulse: apple eaten
hit_evt  in  1  single-cycle pulse: wall/self collision
mute  in  1  level: silence the speaker and drop new events
at_max  in  1  tone strobe from the oscillator
goodColl  out  1  one-cycle request for the eat tone
badColl  out  1  one-cycle request for the hit tone
spk  out  1  square-wave speaker drive
busy  out  1  high when state is not IDLE or any event is pending
osc_fault  out  1  one-cycle pulse when the watchdog aborts a tone

Behaviour:
- Reset: state=IDLE; eat_pend=hit_pend=0; all counters=0; goodColl=badColl=spk=osc_fault=0. busy is combinational and therefore 0.
- Pending flags:
  - An event sets its flag when mute=0; events while mute=1 are discarded.
  - Repeat events of the same type collapse into one pending flag.
  - A flag clears only when its tone is launched. If a same-type event arrives in the launch cycle, the flag stays set (set wins over clear).
- FSM: IDLE -> PLAY -> GAP -> IDLE.
- IDLE:
  - If hit_pend=1, go to PLAY with kind=BAD. Otherwise, if eat_pend=1, go to PLAY with kind=GOOD. hit always wins priority.
  - goodColl or badColl is registered. It is high for exactly the first cycle of PLAY, so the request has 1-cycle latency from the launch decision.
- PLAY:
  - dur counts from 0 starting in the first PLAY cycle.
  - Exit to GAP when dur == LEN-1, where LEN is GOOD_LEN or BAD_LEN, so PLAY lasts exactly LEN cycles.
  - Events arriving during PLAY only latch; there is no preemption.
- spk:
  - In PLAY with mute=0, spk toggles in the cycle after each at_max=1.
  - With mute=1, spk is held at 0, but PLAY timing still runs to completion.
  - spk is forced to 0 on entry to GAP.
- Watchdog:
  - wd counts PLAY cycles since PLAY entry or since the last at_max, and resets to 0 on at_max.
  - If wd reaches WDOG-1 with no at_max, go to GAP, pulse osc_fault for 1 cycle, and force spk to 0.
- GAP: lasts GAP_LEN cycles, then returns to IDLE. at_max is ignored in IDLE and GAP.
- Exit boundary: if at_max coincides with the last PLAY cycle, spk still toggles on that strobe and is then cleared on GAP entry.
- Reset mid-tone: everything returns to reset values immediately; all pending events are lost.
- Widths: dur is CW bits; wd and gap counters are clog2-sized; comparisons are unsigned.

Decomposition:
- Shared game package holds:
  - typedef enum SND_STATE {IDLE, PLAY, GAP};
  - typedef enum SND_KIND {GOOD, BAD};
  - the default GOOD_LEN and BAD_LEN constants, used by both the oscillator and this block.
- One natural sub-module, snd_square: takes the at_max strobe, an enable and a clear, and produces spk. Everything else stays in sound_ctrl.

Test Plan:
Bench settings: GOOD_LEN=40, BAD_LEN=100, GAP_LEN=4, WDOG=16; the at_max model pulses every 5 cycles while its request is active.
1. One eat_evt -> goodColl high for exactly 1 cycle; PLAY lasts 40 cycles; spk makes 8 toggles; after GAP_LEN=4 cycles busy=0.
2. eat_evt and hit_evt in the same cycle -> badColl fires first (PLAY of 100 cycles), then GAP, then goodColl. Only 2 requests in total.
3. Three eat_evt pulses during a PLAY -> exactly one further goodColl after the GAP.
4. The at_max model is disabled -> osc_fault pulses 16 cycles after PLAY entry; spk=0; the block returns to IDLE after the GAP.
5. mute=1 throughout a tone -> spk stays 0 while PLAY still lasts 40 cycles; an eat_evt arriving while muted produces no goodColl.
6. nRst asserted mid-PLAY -> all outputs are 0 asynchronously; after release, busy=0 and no stale request is issued.
